// File: rtl/hazard_unit.sv
// ============================================================================
//  Module   : hazard_unit
//  Purpose  : Pipeline stall/flush controller for a five-stage core (data wait,
//             redirect, load-use, fetch wait, halt). Optional statistics
//             counters are enabled by defining HAZARD_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dreq,
  input  logic [4:0]       de_rs,
  input  logic [4:0]       de_rt,
  input  logic             de_rs_used,
  input  logic             de_rt_used,
  input  logic [4:0]       ex_wsel,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             mem_halt,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_en,
  output logic             em_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] c_RUN    = 2'd0;
  localparam logic [1:0] c_DWAIT  = 2'd1;
  localparam logic [1:0] c_HALTED = 2'd2;

  logic [1:0] r_state;
  logic       w_halted;
  logic       w_dwait;
  logic       w_load_use;
  logic       w_redirect;

  assign w_halted = (r_state == c_HALTED);

  // A miss stalls in the same cycle it is first seen, before DWAIT is entered.
  assign w_dwait = !dhit && ((r_state == c_DWAIT) || (r_state == c_RUN && mem_dreq));

  assign w_load_use = ex_is_load && (ex_wsel != 5'd0) &&
                      ((de_rs_used && (de_rs == ex_wsel)) ||
                       (de_rt_used && (de_rt == ex_wsel)));

  assign w_redirect = !w_halted && !w_dwait && ex_redirect;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= c_RUN;
    end else if (mem_halt && !w_halted) begin
      r_state <= c_HALTED;
    end else if (r_state == c_RUN && mem_dreq && !dhit) begin
      r_state <= c_DWAIT;
    end else if (r_state == c_DWAIT && dhit) begin
      r_state <= c_RUN;
    end
  end

  always_comb begin
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    de_en    = 1'b1;
    em_en    = 1'b1;
    mw_en    = 1'b1;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    if (w_halted || w_dwait) begin
      pc_en = 1'b0;
      fd_en = 1'b0;
      de_en = 1'b0;
      em_en = 1'b0;
      mw_en = 1'b0;
    end else if (ex_redirect) begin
      // pc_en stays high even without ihit so the target PC is captured.
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (w_load_use || !ihit) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_flush = 1'b1;
    end
  end

  assign halted = w_halted;

`ifdef HAZARD_STATS_EN
  logic             w_stall_evt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_stall_evt = !w_halted && (!pc_en || !fd_en);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_redirect && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_count  = r_flush_cnt;
`else
  logic w_unused;
  assign w_unused     = w_redirect;
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
//  Module   : tb_hazard_unit
//  Purpose  : Scoreboard bench for hazard_unit; counter checks follow
//             HAZARD_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit;

  localparam int CNT_W = 4;

  // {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, halted}
  localparam logic [7:0] c_NORM  = 8'b11111_00_0;
  localparam logic [7:0] c_BUBL  = 8'b00111_01_0;
  localparam logic [7:0] c_FRZ   = 8'b00000_00_0;
  localparam logic [7:0] c_REDIR = 8'b11111_11_0;
  localparam logic [7:0] c_HALT  = 8'b00000_00_1;

  typedef struct {
    string            tag;
    logic [7:0]       ctl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  logic CLK = 1'b0;
  logic RST, ihit, dhit, mem_dreq, de_rs_used, de_rt_used;
  logic ex_is_load, ex_redirect, mem_halt;
  logic [4:0] de_rs, de_rt, ex_wsel;
  logic pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, halted;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .de_rs(de_rs), .de_rt(de_rt), .de_rs_used(de_rs_used), .de_rt_used(de_rt_used),
    .ex_wsel(ex_wsel), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mem_halt(mem_halt), .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en),
    .em_en(em_en), .mw_en(mw_en), .fd_flush(fd_flush), .de_flush(de_flush),
    .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs are combinational from state and inputs; sample mid-cycle.
  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".ctl"}, 32'({pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, halted}),
          32'(e.ctl));
      chk({e.tag, ".stall"}, 32'(stall_cycles), 32'(e.stall));
      chk({e.tag, ".flush"}, 32'(flush_count), 32'(e.flush));
    end
  end

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; mem_dreq = 1'b0;
    de_rs = 5'd0; de_rt = 5'd0; de_rs_used = 1'b0; de_rt_used = 1'b0;
    ex_wsel = 5'd0; ex_is_load = 1'b0; ex_redirect = 1'b0; mem_halt = 1'b0;
  endtask

  // Inputs are already set; queue expectation, then advance one clock.
  task automatic cyc(input string tag, input logic [7:0] ctl);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.stall = exp_stall; e.flush = exp_flush;
    sb.push_back(e);
`ifdef HAZARD_STATS_EN
    if (!ctl[0] && (!ctl[7] || !ctl[6]) && exp_stall != '1) exp_stall = exp_stall + 1'b1;
    if (ctl == c_REDIR && exp_flush != '1) exp_flush = exp_flush + 1'b1;
`endif
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
  endtask

  initial begin
    idle();
    do_reset();
    cyc("reset_norm", c_NORM);

    ex_is_load = 1; ex_wsel = 5'd5; de_rs = 5'd5; de_rs_used = 1;
    cyc("lu_rs", c_BUBL);
    ex_is_load = 0;
    cyc("lu_clear", c_NORM);

    idle(); ex_is_load = 1; ex_wsel = 5'd9; de_rt = 5'd9; de_rt_used = 1;
    cyc("lu_rt", c_BUBL);
    idle(); ex_is_load = 1; ex_wsel = 5'd9; de_rs = 5'd9; de_rs_used = 0;
    cyc("lu_unused", c_NORM);
    idle(); ex_is_load = 1; ex_wsel = 5'd0; de_rs = 5'd0; de_rs_used = 1;
    cyc("lu_r0", c_NORM);

    idle(); ihit = 0;
    cyc("fetch_wait", c_BUBL);

    idle(); mem_dreq = 1;
    cyc("dwait0", c_FRZ);
    ex_redirect = 1;
    cyc("dwait1_redir", c_FRZ);
    ex_redirect = 0; ihit = 0;
    cyc("dwait2_nohit", c_FRZ);
    ihit = 1; dhit = 1;
    cyc("dhit", c_NORM);
    idle();
    cyc("after_dhit", c_NORM);

    ex_redirect = 1; ex_is_load = 1; ex_wsel = 5'd7; de_rt = 5'd7; de_rt_used = 1;
    cyc("redir_lu", c_REDIR);
    idle(); ex_redirect = 1; ihit = 0;
    cyc("redir_nohit", c_REDIR);
    idle();
    cyc("redir_done", c_NORM);

    mem_halt = 1;
    @(posedge CLK); #1;
    idle();
    cyc("halt0", c_HALT);
    ex_redirect = 1; ihit = 0; mem_dreq = 1; dhit = 1;
    cyc("halt1", c_HALT);
    idle(); ex_is_load = 1; ex_wsel = 5'd3; de_rs = 5'd3; de_rs_used = 1; mem_halt = 1;
    cyc("halt2", c_HALT);
    idle();
    do_reset();
    cyc("post_halt_rst", c_NORM);

    ihit = 0;
    for (int i = 0; i < 20; i++) cyc($sformatf("sat%0d", i), c_BUBL);
    idle();
    cyc("sat_end", c_NORM);

    idle(); mem_dreq = 1;
    cyc("dwait_rst0", c_FRZ);
    do_reset();
    idle();
    cyc("dwait_rst1", c_NORM);

    @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of statistics counters.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ihit  input  1  instruction fetch completed this cycle.
REQ-005 SHALL have port dhit  input  1  data access completed this cycle.
REQ-006 SHALL have port mem_dreq  input  1  memory-stage instruction issues dmemREN or dmemWEN.
REQ-007 SHALL have ports de_rs, de_rt  input  5  source registers of the instruction in decode.
REQ-008 SHALL have ports de_rs_used, de_rt_used  input  1  each source is actually read.
REQ-009 SHALL have port ex_wsel  input  5  exec-stage destination register.
REQ-010 SHALL have port ex_is_load  input  1  exec-stage wdat_source is WRITE_RAM.
REQ-011 SHALL have port ex_redirect  input  1  branch taken or jump resolved in exec.
REQ-012 SHALL have port mem_halt  input  1  HALT has reached memory stage.
REQ-013 SHALL have outputs pc_en, fd_en, de_en, em_en, mw_en  1 each  latch enables.
REQ-014 SHALL have outputs fd_flush, de_flush  1 each  load a bubble (nop, wsel=0) into that latch.
REQ-015 SHALL have output halted  1  core permanently stopped.
REQ-016 SHALL have outputs stall_cycles, flush_count  CNT_W each  statistics (see Configuration).

Function
REQ-017 SHALL hold a registered state in {RUN, DWAIT, HALTED}; all other outputs combinational from state and inputs.
REQ-018 RUN->DWAIT when mem_dreq && !dhit; DWAIT->RUN on the cycle dhit=1; any state->HALTED when mem_halt=1 and not already HALTED.
REQ-019 Priority per cycle: HALTED > data wait > redirect > load-use > fetch wait > normal.
REQ-020 HALTED: all enables 0, flushes 0, halted=1; stays until RST.
REQ-021 Data wait (DWAIT, or RUN with mem_dreq && !dhit): all five enables 0, flushes 0; the cycle dhit rises, all enables 1.
REQ-022 Redirect (ex_redirect=1, no data wait): pc_en=1, fd_flush=1, de_flush=1, em_en=mw_en=1; exactly one cycle per resolved redirect.
REQ-023 Load-use: ex_is_load && ex_wsel!=0 && ((de_rs_used && de_rs==ex_wsel) || (de_rt_used && de_rt==ex_wsel)); response pc_en=fd_en=0, de_flush=1, em_en=mw_en=1; naturally clears after one bubble.
REQ-024 Register 0 SHALL never create a load-use hazard.
REQ-025 Fetch wait (!ihit, no higher event): pc_en=fd_en=0, de_flush=1, em_en=mw_en=1.
REQ-026 Normal: all enables 1, flushes 0.
REQ-027 A flush and an enable on the same latch SHALL both be 1 (flush loads bubble on the enabled edge).
REQ-028 Redirect coincident with !ihit SHALL still assert pc_en=1 so the target PC is captured.

Reset
REQ-029 On RST=1 at a clock edge: state=RUN, counters=0, halted=0; outputs are then those of RUN with current inputs.
REQ-030 RST asserted during DWAIT or HALTED SHALL return to RUN on that edge.

Configuration
REQ-031 Macro HAZARD_STATS_EN: when defined, stall_cycles increments each cycle any of pc_en/fd_en is 0 outside HALTED, flush_count increments each redirect cycle; both saturate at all-ones.
REQ-032 Without HAZARD_STATS_EN, stall_cycles and flush_count SHALL be constant 0 and no counter flops exist.

Verification
REQ-033 ex_is_load=1, ex_wsel=5, de_rs=5, de_rs_used=1 -> one cycle pc_en=0, fd_en=0, de_flush=1; next cycle (ex_is_load=0) all enables 1.
REQ-034 mem_dreq=1, dhit=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, state DWAIT, enables 1 on dhit cycle, state RUN.
REQ-035 ex_redirect=1 with ex_is_load=1 and matching de_rt=7 -> fd_flush=de_flush=pc_en=1, load-use ignored; flush_count +1 with HAZARD_STATS_EN.
REQ-036 ex_wsel=0, ex_is_load=1, de_rs=0, de_rs_used=1 -> no stall, all enables 1.
REQ-037 mem_halt=1 -> halted=1 next cycle, all enables 0 while inputs toggle; RST=1 -> RUN, halted=0, counters 0.
REQ-038 HAZARD_STATS_EN defined, counter preloaded near all-ones via 2^CNT_W stall cycles (CNT_W=4) -> stall_cycles holds at 15.
